lift_queue_reader: RTL and testbench

Consumer side of the lift request queue: takes the head entry of the 16x4 request RAM, drives the car floor by floor to that target, holds the door open, then pops the entry with a one-cycle `shift` pulse. It sits between the request-queue RAM and the car/door actuator outputs. It never writes queue contents. The request-entry logic appends and inserts entries; this block only reads and removes them.

---
 rtl/lift_queue_reader.sv | 153 +++++++++++++++
 tb/tb_lift_queue_reader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/lift_queue_reader.sv
// Consumer side of the lift request queue: fetches the head entry, drives the
// car floor by floor to it, holds the door open, then pops the entry.
// Ports:
//   clk, reset_n (async, active low)
//   empty, q      : queue status and head entry (target floor)
//   hold          : door-hold request
//   shift         : one-cycle pop pulse to the queue
//   floor         : current car floor
//   moving_up/dn  : travel direction outputs
//   door_open     : door state
//   busy          : high outside IDLE
//   bad_req       : pulse when an invalid entry is discarded
module lift_queue_reader #(
  parameter int unsigned MOVE_CYCLES = 4,
  parameter int unsigned DOOR_CYCLES = 8,
  parameter int unsigned MAX_FLOOR   = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       empty,
  input  logic [3:0] q,
  input  logic       hold,
  output logic       shift,
  output logic [3:0] floor,
  output logic       moving_up,
  output logic       moving_down,
  output logic       door_open,
  output logic       busy,
  output logic       bad_req
);

  localparam int MTW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
  localparam int DTW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [MTW-1:0] MOVE_LAST = MTW'(MOVE_CYCLES - 1);
  localparam logic [DTW-1:0] DOOR_LAST = DTW'(DOOR_CYCLES - 1);
  localparam logic [3:0] MAXF = 4'(MAX_FLOOR);

  typedef enum logic [2:0] {
    IDLE, FETCH, MOVE, DOOR, POP, SETTLE
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     floor_q, floor_d;
  logic [3:0]     target_q, target_d;
  logic           dir_q, dir_d;
  logic [MTW-1:0] mtmr_q, mtmr_d;
  logic [DTW-1:0] dtmr_q, dtmr_d;

  logic shift_q, shift_d;
  logic up_q, up_d;
  logic dn_q, dn_d;
  logic door_q, door_d;
  logic busy_q, busy_d;
  logic bad_q, bad_d;

  logic [3:0] step_f;
  logic       at_lim;
  logic       q_bad;

  // dir_q: 1 = up. at_lim guards against stepping past the shaft ends.
  assign step_f = dir_q ? floor_q + 4'd1 : floor_q - 4'd1;
  assign at_lim = dir_q ? (floor_q >= MAXF) : (floor_q == 4'd0);
  assign q_bad  = q > MAXF;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      floor_q  <= '0;
      target_q <= '0;
      dir_q    <= 1'b0;
      mtmr_q   <= '0;
      dtmr_q   <= '0;
      shift_q  <= 1'b0;
      up_q     <= 1'b0;
      dn_q     <= 1'b0;
      door_q   <= 1'b0;
      busy_q   <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      floor_q  <= floor_d;
      target_q <= target_d;
      dir_q    <= dir_d;
      mtmr_q   <= mtmr_d;
      dtmr_q   <= dtmr_d;
      shift_q  <= shift_d;
      up_q     <= up_d;
      dn_q     <= dn_d;
      door_q   <= door_d;
      busy_q   <= busy_d;
      bad_q    <= bad_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    floor_d  = floor_q;
    target_d = target_q;
    dir_d    = dir_q;
    mtmr_d   = '0;
    dtmr_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (!empty) state_d = FETCH;
      end
      FETCH: begin
        target_d = q;
        dir_d    = q > floor_q;
        if (q_bad)             state_d = POP;
        else if (q == floor_q) state_d = DOOR;
        else                   state_d = MOVE;
      end
      MOVE: begin
        if (mtmr_q != MOVE_LAST) begin
          mtmr_d = mtmr_q + MTW'(1);
        end else if (at_lim) begin
          state_d = DOOR;
        end else begin
          floor_d = step_f;
          if (step_f == target_q) state_d = DOOR;
        end
      end
      DOOR: begin
        // hold restarts the open period from zero
        if (hold)                    dtmr_d = '0;
        else if (dtmr_q == DOOR_LAST) state_d = POP;
        else                         dtmr_d = dtmr_q + DTW'(1);
      end
      POP:     state_d = SETTLE;
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs, registered from the state being entered
  always_comb begin
    shift_d = state_d == POP;
    up_d    = (state_d == MOVE) & dir_d;
    dn_d    = (state_d == MOVE) & ~dir_d;
    door_d  = state_d == DOOR;
    busy_d  = state_d != IDLE;
    bad_d   = (state_q == FETCH) & q_bad;
  end

  assign shift       = shift_q;
  assign floor       = floor_q;
  assign moving_up   = up_q;
  assign moving_down = dn_q;
  assign door_open   = door_q;
  assign busy        = busy_q;
  assign bad_req     = bad_q;

endmodule

// File: tb/tb_lift_queue_reader.sv
// Testbench for lift_queue_reader: cycle-exact vector table plus directed
// sequences for door hold, long trips, target latching and mid-move reset.
module tb_lift_queue_reader;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       empty = 1'b1;
  logic [3:0] q = 4'd0;
  logic       hold = 1'b0;
  logic       shift, moving_up, moving_down, door_open, busy, bad_req;
  logic [3:0] floor;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  lift_queue_reader #(
    .MOVE_CYCLES(4),
    .DOOR_CYCLES(8),
    .MAX_FLOOR  (9)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .empty      (empty),
    .q          (q),
    .hold       (hold),
    .shift      (shift),
    .floor      (floor),
    .moving_up  (moving_up),
    .moving_down(moving_down),
    .door_open  (door_open),
    .busy       (busy),
    .bad_req    (bad_req)
  );

  typedef struct {
    logic       e;
    logic [3:0] q;
    logic       h;
    int         n;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[$];

  // {shift, floor, up, down, door, busy, bad}
  function automatic logic [9:0] ov(logic s, logic [3:0] f, logic u,
                                    logic d, logic dr, logic b, logic bd);
    return {s, f, u, d, dr, b, bd};
  endfunction

  function automatic logic [9:0] obs();
    return {shift, floor, moving_up, moving_down,
            door_open, busy, bad_req};
  endfunction

  task automatic add(logic e, logic [3:0] qq, logic h, int n,
                     logic [9:0] exp);
    vec_t v;
    v.e = e; v.q = qq; v.h = h; v.n = n; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic trip(input logic [3:0] tgt, input logic [3:0] alt,
                      output int up_n, output int dn_n,
                      output int door_n, output int sh_n,
                      output int excl, output logic [3:0] dfl,
                      output logic tmo);
    up_n = 0; dn_n = 0; door_n = 0; sh_n = 0; excl = 0;
    dfl = 4'hF; tmo = 1'b1;
    empty = 1'b0;
    q = tgt;
    for (int c = 0; c < 300; c++) begin
      step();
      if (c == 1) q = alt;
      if (moving_up) up_n++;
      if (moving_down) dn_n++;
      if (door_open) begin
        if (door_n == 0) dfl = floor;
        door_n++;
      end
      if (shift) begin
        sh_n++;
        empty = 1'b1;
      end
      if ((moving_up && moving_down) ||
          ((moving_up || moving_down) && door_open)) excl++;
      if (!busy) begin
        tmo = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int up_n, dn_n, door_n, sh_n, excl, cnt;
    logic [3:0] dfl;
    logic tmo;

    // test 1: idle with empty queue
    add(1, 0, 0, 50, ov(0, 0, 0, 0, 0, 0, 0));
    // test 2: floor 0 -> 3
    add(0, 3, 0, 1, ov(0, 0, 0, 0, 0, 1, 0));
    add(0, 3, 0, 4, ov(0, 0, 1, 0, 0, 1, 0));
    add(0, 3, 0, 4, ov(0, 1, 1, 0, 0, 1, 0));
    add(0, 3, 0, 4, ov(0, 2, 1, 0, 0, 1, 0));
    add(0, 3, 0, 8, ov(0, 3, 0, 0, 1, 1, 0));
    add(0, 3, 0, 1, ov(1, 3, 0, 0, 0, 1, 0));
    add(1, 0, 0, 1, ov(0, 3, 0, 0, 0, 1, 0));
    add(1, 0, 0, 3, ov(0, 3, 0, 0, 0, 0, 0));
    // test 3: same floor, then 3 -> 1
    add(0, 3, 0, 1, ov(0, 3, 0, 0, 0, 1, 0));
    add(0, 3, 0, 8, ov(0, 3, 0, 0, 1, 1, 0));
    add(0, 3, 0, 1, ov(1, 3, 0, 0, 0, 1, 0));
    add(0, 1, 0, 1, ov(0, 3, 0, 0, 0, 1, 0));
    add(0, 1, 0, 1, ov(0, 3, 0, 0, 0, 0, 0));
    add(0, 1, 0, 1, ov(0, 3, 0, 0, 0, 1, 0));
    add(0, 1, 0, 4, ov(0, 3, 0, 1, 0, 1, 0));
    add(0, 1, 0, 4, ov(0, 2, 0, 1, 0, 1, 0));
    add(0, 1, 0, 8, ov(0, 1, 0, 0, 1, 1, 0));
    add(0, 1, 0, 1, ov(1, 1, 0, 0, 0, 1, 0));
    add(1, 0, 0, 1, ov(0, 1, 0, 0, 0, 1, 0));
    add(1, 0, 0, 2, ov(0, 1, 0, 0, 0, 0, 0));
    // test 5: invalid head 12 with MAX_FLOOR 9
    add(0, 12, 0, 1, ov(0, 1, 0, 0, 0, 1, 0));
    add(0, 12, 0, 1, ov(1, 1, 0, 0, 0, 1, 1));
    add(1, 0, 0, 1, ov(0, 1, 0, 0, 0, 1, 0));
    add(1, 0, 0, 2, ov(0, 1, 0, 0, 0, 0, 0));

    step();
    step();
    check("reset_state", 32'(obs()), 32'(ov(0, 0, 0, 0, 0, 0, 0)));
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      for (int j = 0; j < tbl[i].n; j++) begin
        empty = tbl[i].e;
        q     = tbl[i].q;
        hold  = tbl[i].h;
        step();
        check($sformatf("vec%0d.%0d", i, j), 32'(obs()),
              32'(tbl[i].exp));
      end
    end

    // test 4: hold during the first 5 door cycles at floor 1
    empty = 1'b0;
    q = 4'd1;
    step();
    check("hold_fetch", 32'(obs()), 32'(ov(0, 1, 0, 0, 0, 1, 0)));
    step();
    check("hold_door_in", 32'(obs()), 32'(ov(0, 1, 0, 0, 1, 1, 0)));
    cnt = 1;
    for (int i = 0; i < 40; i++) begin
      hold = (i < 5);
      step();
      if (door_open) cnt++;
      else break;
    end
    hold = 1'b0;
    empty = 1'b1;
    check("hold_door_len", 32'(cnt), 32'd13);
    check("hold_pop", 32'(obs()), 32'(ov(1, 1, 0, 0, 0, 1, 0)));
    step();
    step();
    check("hold_idle", 32'(obs()), 32'(ov(0, 1, 0, 0, 0, 0, 0)));

    // trip to MAX_FLOOR; head changes to 5 mid-move must be ignored
    trip(4'd9, 4'd5, up_n, dn_n, door_n, sh_n, excl, dfl, tmo);
    check("t9_timeout", 32'(tmo), 32'd0);
    check("t9_up", 32'(up_n), 32'd32);
    check("t9_dn", 32'(dn_n), 32'd0);
    check("t9_floor", 32'(dfl), 32'd9);
    check("t9_door", 32'(door_n), 32'd8);
    check("t9_shift", 32'(sh_n), 32'd1);
    check("t9_excl", 32'(excl), 32'd0);

    // trip down to floor 2
    trip(4'd2, 4'd2, up_n, dn_n, door_n, sh_n, excl, dfl, tmo);
    check("t2_timeout", 32'(tmo), 32'd0);
    check("t2_dn", 32'(dn_n), 32'd28);
    check("t2_up", 32'(up_n), 32'd0);
    check("t2_floor", 32'(dfl), 32'd2);
    check("t2_excl", 32'(excl), 32'd0);

    // test 6: reset mid-move from floor 2 towards 5
    empty = 1'b0;
    q = 4'd5;
    step();
    step();
    step();
    step();
    check("r_midmove", 32'(obs()), 32'(ov(0, 2, 1, 0, 0, 1, 0)));
    #2;
    reset_n = 1'b0;
    #1;
    check("r_async", 32'(obs()), 32'(ov(0, 0, 0, 0, 0, 0, 0)));
    step();
    check("r_held", 32'(obs()), 32'(ov(0, 0, 0, 0, 0, 0, 0)));
    reset_n = 1'b1;
    trip(4'd5, 4'd5, up_n, dn_n, door_n, sh_n, excl, dfl, tmo);
    check("r_timeout", 32'(tmo), 32'd0);
    check("r_up", 32'(up_n), 32'd20);
    check("r_floor", 32'(dfl), 32'd5);
    check("r_shift", 32'(sh_n), 32'd1);
    check("r_excl", 32'(excl), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
